// File: rtl/mindfocus_pkg.sv
// Shared definitions for the mindfocus game datapath and controllers:
// state codes, bus widths and board timing defaults.
package mindfocus_pkg;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DATA_W     = 4;
    localparam int unsigned T_SHOW_DEF = 1000;
    localparam int unsigned T_GAP_DEF  = 250;

    // Enum values double as the db_estado codes shown on hexa7seg.
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        MOSTRA  = 3'd2,
        PAUSA   = 3'd3,
        FIM     = 3'd4
    } estado_t;

    function automatic logic [3:0] codigo_estado(input estado_t e);
        return {1'b0, e};
    endfunction

endpackage

// File: rtl/sequenciador_exibicao_contador_tempo.sv
// Down-counter shared by the show and gap intervals; holds at zero and
// flags fim_tempo while the count is zero.
module contador_tempo #(
    parameter int unsigned W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic         zera,
    input  logic [W-1:0] valor,
    output logic         fim_tempo
);

    logic [W-1:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (zera) begin
            cont_d = '0;
        end else if (carrega) begin
            cont_d = valor;
        end else if (cont_q != '0) begin
            cont_d = cont_q - W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign fim_tempo = (cont_q == '0);

endmodule

// File: rtl/sequenciador_exibicao.sv
// Plays the stored sequence (addresses 0..rodada) on the LEDs before each
// round: load, show for T_SHOW cycles, blank for T_GAP cycles, then pulse fim.
module sequenciador_exibicao
    import mindfocus_pkg::*;
#(
    parameter int unsigned T_SHOW = T_SHOW_DEF,
    parameter int unsigned T_GAP  = T_GAP_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar_exib,
    input  logic              voltar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              fim,
    output logic [3:0]        db_estado
);

    localparam int unsigned T_MAX = (T_SHOW > T_GAP) ? T_SHOW : T_GAP;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] V_SHOW = TW'(T_SHOW - 1);
    localparam logic [TW-1:0] V_GAP  = TW'(T_GAP - 1);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] rod_q, rod_d;
    logic [DATA_W-1:0] leds_q, leds_d;

    logic              t_carrega;
    logic              t_zera;
    logic [TW-1:0]     t_valor;
    logic              fim_tempo;

    contador_tempo #(
        .W (TW)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .carrega   (t_carrega),
        .zera      (t_zera),
        .valor     (t_valor),
        .fim_tempo (fim_tempo)
    );

    always_comb begin
        estado_d  = estado_q;
        end_d     = end_q;
        rod_d     = rod_q;
        leds_d    = leds_q;
        t_carrega = 1'b0;
        t_zera    = 1'b0;
        t_valor   = '0;

        if (voltar) begin
            estado_d = OCIOSO;
            end_d    = '0;
            leds_d   = '0;
            t_zera   = 1'b1;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (iniciar_exib) begin
                        rod_d    = rodada;
                        end_d    = '0;
                        estado_d = CARREGA;
                    end
                end
                CARREGA: begin
                    leds_d    = mem_dado;
                    t_carrega = 1'b1;
                    t_valor   = V_SHOW;
                    estado_d  = MOSTRA;
                end
                MOSTRA: begin
                    if (fim_tempo) begin
                        leds_d    = '0;
                        t_carrega = 1'b1;
                        t_valor   = V_GAP;
                        estado_d  = PAUSA;
                    end
                end
                PAUSA: begin
                    // Exit test before the increment keeps endereco from wrapping at 15.
                    if (fim_tempo) begin
                        if (end_q == rod_q) begin
                            estado_d = FIM;
                        end else begin
                            end_d    = end_q + ADDR_W'(1);
                            estado_d = CARREGA;
                        end
                    end
                end
                FIM: begin
                    estado_d = OCIOSO;
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            end_q    <= '0;
            rod_q    <= '0;
            leds_q   <= '0;
        end else begin
            estado_q <= estado_d;
            end_q    <= end_d;
            rod_q    <= rod_d;
            leds_q   <= leds_d;
        end
    end

    assign endereco  = end_q;
    assign leds      = leds_q;
    assign ocupado   = (estado_q != OCIOSO);
    assign fim       = (estado_q == FIM);
    assign db_estado = codigo_estado(estado_q);

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Directed bench for sequenciador_exibicao with T_SHOW=4, T_GAP=2, checked
// every cycle against a timeline model plus hand-computed cycle expectations.
module tb_sequenciador_exibicao;

    localparam int TS = 4;
    localparam int TG = 2;
    localparam int P  = 1 + TS + TG;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar_exib;
    logic       voltar;
    logic [3:0] rodada;
    logic [3:0] mem_dado = '0;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int s      = 0;
    int fim_count = 0;
    int last_fim  = -1;
    int max_end   = 0;

    // Timeline model: m_k is the cycle number inside the current playback.
    bit         m_busy;
    int         m_k;
    int         m_R;
    logic [3:0] m_addr;

    sequenciador_exibicao #(
        .T_SHOW (TS),
        .T_GAP  (TG)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar_exib (iniciar_exib),
        .voltar       (voltar),
        .rodada       (rodada),
        .mem_dado     (mem_dado),
        .endereco     (endereco),
        .leds         (leds),
        .ocupado      (ocupado),
        .fim          (fim),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Memory read register clocked mid-cycle so data for endereco is ready at the next edge.
    always @(negedge clock) mem_dado <= mem[endereco];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_k = 0; m_R = 0; m_addr = '0;
        end else begin
            cyc++;
            if (voltar) begin
                m_busy = 0; m_addr = '0;
            end else if (!m_busy) begin
                if (iniciar_exib) begin
                    m_busy = 1; m_k = 1; m_R = int'(rodada); m_addr = '0;
                end
            end else if (m_k == 1 + (m_R + 1) * P) begin
                m_busy = 0; m_addr = 4'(m_R);
            end else begin
                m_k++;
            end
        end
    end

    always begin
        int e_led, e_end, e_st, e_oc, e_fim, a, ph;
        @(posedge clock);
        #1;
        if (!reset) begin
            if (!m_busy) begin
                e_led = 0; e_end = int'(m_addr); e_st = 0; e_oc = 0; e_fim = 0;
            end else if (m_k == 1 + (m_R + 1) * P) begin
                e_led = 0; e_end = m_R; e_st = 4; e_oc = 1; e_fim = 1;
            end else begin
                a  = (m_k - 1) / P;
                ph = (m_k - 1) % P;
                e_end = a; e_oc = 1; e_fim = 0;
                if (ph == 0) begin
                    e_led = 0; e_st = 1;
                end else if (ph <= TS) begin
                    e_led = int'(mem[a]); e_st = 2;
                end else begin
                    e_led = 0; e_st = 3;
                end
            end
            check("leds", int'(leds), e_led);
            check("endereco", int'(endereco), e_end);
            check("db_estado", int'(db_estado), e_st);
            check("ocupado", int'(ocupado), e_oc);
            check("fim", int'(fim), e_fim);
            if (fim) begin
                fim_count++;
                last_fim = cyc;
            end
            if (int'(endereco) > max_end) max_end = int'(endereco);
        end
    end

    // Cycle k of a playback (cycle 1 = CARREGA of address 0) is observed when cyc == s + k - 1.
    task automatic goto(input int k);
        while (cyc - s + 1 < k) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic start_play(input logic [3:0] r);
        @(negedge clock);
        rodada = r;
        iniciar_exib = 1'b1;
        @(posedge clock);
        #2;
        s = cyc;
        iniciar_exib = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f0;
        reset = 1'b1; iniciar_exib = 1'b0; voltar = 1'b0; rodada = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(negedge clock);
        check("rst_leds", int'(leds), 0);
        check("rst_endereco", int'(endereco), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_fim", int'(fim), 0);
        check("rst_db_estado", int'(db_estado), 0);
        reset = 1'b0;

        // Single pattern
        mem[0] = 4'b0101;
        f0 = fim_count;
        start_play(4'd0);
        goto(2); check("single_leds_c2", int'(leds), 5);
        goto(5); check("single_leds_c5", int'(leds), 5);
        goto(6); check("single_leds_c6", int'(leds), 0);
        goto(8); check("single_fim_c8", int'(fim), 1);
        goto(9);
        check("single_ocupado_c9", int'(ocupado), 0);
        check("single_fim_cycle", last_fim - s + 1, 8);
        check("single_fim_count", fim_count - f0, 1);

        // Asynchronous reset mid-MOSTRA
        start_play(4'd2);
        goto(3);
        check("pre_rst_leds", int'(leds), 5);
        #1 reset = 1'b1;
        #1;
        check("async_leds", int'(leds), 0);
        check("async_endereco", int'(endereco), 0);
        check("async_ocupado", int'(ocupado), 0);
        check("async_db_estado", int'(db_estado), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Full sequence
        mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
        f0 = fim_count; max_end = 0;
        start_play(4'd3);
        goto(2);  check("full_leds_c2", int'(leds), 1);
        goto(9);  check("full_leds_c9", int'(leds), 2);
        goto(16); check("full_leds_c16", int'(leds), 4);
        goto(23); check("full_leds_c23", int'(leds), 8);
        goto(30);
        check("full_fim_cycle", last_fim - s + 1, 29);
        check("full_fim_count", fim_count - f0, 1);
        check("full_max_endereco", max_end, 3);

        // Start requests while busy are ignored
        f0 = fim_count; max_end = 0;
        start_play(4'd3);
        goto(3);  iniciar_exib = 1'b1; rodada = 4'd7;
        goto(4);  iniciar_exib = 1'b0;
        goto(10); iniciar_exib = 1'b1;
        goto(11); iniciar_exib = 1'b0;
        goto(30);
        check("busy_fim_cycle", last_fim - s + 1, 29);
        check("busy_max_endereco", max_end, 3);
        goto(45);
        check("busy_fim_count", fim_count - f0, 1);
        check("busy_ocupado_idle", int'(ocupado), 0);

        // Abort during PAUSA of address 1
        f0 = fim_count;
        start_play(4'd3);
        goto(13);
        check("abort_in_pausa", int'(db_estado), 3);
        check("abort_addr_1", int'(endereco), 1);
        voltar = 1'b1;
        goto(14);
        voltar = 1'b0;
        check("abort_ocupado", int'(ocupado), 0);
        check("abort_leds", int'(leds), 0);
        check("abort_endereco", int'(endereco), 0);
        goto(35);
        check("abort_no_fim", fim_count - f0, 0);
        start_play(4'd3);
        goto(2);
        check("replay_leds_c2", int'(leds), 1);
        check("replay_endereco_c2", int'(endereco), 0);
        goto(30);
        check("replay_fim_cycle", last_fim - s + 1, 29);

        // Maximum round
        for (int i = 0; i < 16; i++) mem[i] = 4'(i) ^ 4'hA;
        f0 = fim_count; max_end = 0;
        start_play(4'd15);
        goto(2);   check("max_leds_c2", int'(leds), 10);
        goto(107);
        check("max_leds_c107", int'(leds), 5);
        check("max_endereco_c107", int'(endereco), 15);
        goto(114);
        check("max_fim_cycle", last_fim - s + 1, 113);
        check("max_fim_count", fim_count - f0, 1);
        check("max_endereco_end", int'(endereco), 15);
        check("max_max_endereco", max_end, 15);

        goto(118);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
